// File: rtl/spinvaders_pkg.sv
// Shared encodings and constants for the Space Invaders game-flow controller.
package spinvaders_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_HIT  = 3'd3,
    ST_WIN  = 3'd4,
    ST_LOSE = 3'd5
  } game_state_t;

  localparam logic [9:0] SCORE_INC = 10'd10;
  localparam logic [9:0] SCORE_CAP = 10'd999;
  localparam logic [3:0] ALIEN_MAX = 4'd15;

  // Saturating score add: never passes the 3-digit display limit.
  function automatic logic [9:0] score_add(input logic [9:0] s);
    return (s > (SCORE_CAP - SCORE_INC)) ? SCORE_CAP : (s + SCORE_INC);
  endfunction

endpackage

// File: rtl/spinvaders_frame_div.sv
// Free-running frame divider: one-cycle frame pulse every FRAME_DIV clocks,
// first asserted FRAME_DIV-1 cycles after reset release.
module spinvaders_frame_div #(
  parameter int FRAME_DIV = 833333
) (
  input  logic Clk,
  input  logic reset,
  output logic frame
);

  localparam int CW = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign frame = (cnt == LAST);

endmodule

// File: rtl/spinvaders_game_ctrl.sv
// Game-flow FSM, tick scheduler, score and lives for the Space Invaders datapath.
// All tick/load outputs are single-cycle strobes; consumers act on any cycle they are high.
module spinvaders_game_ctrl
  import spinvaders_pkg::*;
#(
  parameter int FRAME_DIV  = 833333,
  parameter int MARCH_MIN  = 4,
  parameter int MARCH_STEP = 2,
  parameter int RETURN_PER = 2,
  parameter int HIT_FRAMES = 90,
  parameter int LIVES_INIT = 3
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       start,
  input  logic       alien_hit,
  input  logic       player_hit,
  input  logic [3:0] aliens_left,
  input  logic       invaded,
  output logic       dp_load,
  output logic       ship_tick,
  output logic       shot_tick,
  output logic       march_tick,
  output logic       return_tick,
  output logic [2:0] state,
  output logic [9:0] score,
  output logic [1:0] lives
);

  localparam int HW = $clog2(HIT_FRAMES + 1);

  game_state_t st, st_nxt;
  logic          frame;
  logic          start_q;
  logic [7:0]    march_cnt, ret_cnt, march_per;
  logic [HW-1:0] hit_cnt;
  logic          march_due, ret_due, hit_done, in_play;

  spinvaders_frame_div #(.FRAME_DIV(FRAME_DIV)) u_frame_div (
    .Clk   (Clk),
    .reset (reset),
    .frame (frame)
  );

  // Period re-evaluated every frame, so a shrinking fleet ticks on the next frame.
  assign march_per = 8'(MARCH_MIN) + 8'(MARCH_STEP) * {4'd0, aliens_left};
  assign march_due = (march_cnt + 8'd1) >= march_per;
  assign ret_due   = (ret_cnt + 8'd1) >= 8'(RETURN_PER);
  assign hit_done  = frame && (hit_cnt == HW'(HIT_FRAMES - 1));
  assign state     = st;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) st <= ST_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: if (start) st_nxt = ST_LOAD;
      ST_LOAD: st_nxt = ST_PLAY;
      ST_PLAY: begin
        if (aliens_left == 4'd0)  st_nxt = ST_WIN;
        else if (invaded)         st_nxt = ST_LOSE;
        else if (player_hit)      st_nxt = (lives <= 2'd1) ? ST_LOSE : ST_HIT;
      end
      ST_HIT:  if (hit_done) st_nxt = ST_LOAD;
      ST_WIN, ST_LOSE: if (start && !start_q) st_nxt = ST_IDLE;
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_play     = (st == ST_PLAY);
    dp_load     = (st == ST_LOAD);
    ship_tick   = in_play && frame;
    shot_tick   = in_play && frame;
    march_tick  = in_play && frame && march_due;
    return_tick = in_play && frame && ret_due;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      start_q   <= 1'b0;
      score     <= '0;
      lives     <= 2'(LIVES_INIT);
      march_cnt <= '0;
      ret_cnt   <= '0;
      hit_cnt   <= '0;
    end else begin
      start_q <= start;
      case (st)
        ST_IDLE: if (start) begin
          score <= '0;
          lives <= 2'(LIVES_INIT);
        end
        ST_LOAD: begin
          march_cnt <= '0;
          ret_cnt   <= '0;
          hit_cnt   <= '0;
        end
        ST_PLAY: begin
          if (frame) begin
            march_cnt <= march_due ? 8'd0 : march_cnt + 8'd1;
            ret_cnt   <= ret_due ? 8'd0 : ret_cnt + 8'd1;
          end
          if (aliens_left != 4'd0) begin
            if (invaded)         lives <= 2'd0;
            else if (player_hit) lives <= lives - 2'd1;
          end
        end
        ST_HIT: if (frame) hit_cnt <= hit_done ? '0 : hit_cnt + 1'b1;
        default: ;
      endcase
      if ((st == ST_PLAY || st == ST_HIT) && alien_hit) score <= score_add(score);
    end
  end

endmodule

// File: tb/tb_spinvaders_game_ctrl.sv
// Scoreboarded bench for spinvaders_game_ctrl: directed game scenarios with
// hand-computed state/lives, score and dp_load expectations.
module tb_spinvaders_game_ctrl;
  import spinvaders_pkg::*;

  localparam int FDIV = 4;
  localparam int HITF = 3;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       alien_hit = 1'b0;
  logic       player_hit = 1'b0;
  logic       invaded = 1'b0;
  logic [3:0] aliens_left = ALIEN_MAX;
  logic       dp_load, ship_tick, shot_tick, march_tick, return_tick;
  logic [2:0] state;
  logic [9:0] score;
  logic [1:0] lives;

  int n_checks = 0;
  int n_pass = 0;

  logic [4:0] exp_st_q[$];
  logic [9:0] exp_score_q[$];
  logic [2:0] exp_load_q[$];
  int exp_march_gap = 0;
  bit mon_en = 1'b0;

  spinvaders_game_ctrl #(
    .FRAME_DIV(FDIV), .MARCH_MIN(4), .MARCH_STEP(2),
    .RETURN_PER(2), .HIT_FRAMES(HITF), .LIVES_INIT(3)
  ) dut (
    .Clk(Clk), .reset(reset), .start(start), .alien_hit(alien_hit),
    .player_hit(player_hit), .aliens_left(aliens_left), .invaded(invaded),
    .dp_load(dp_load), .ship_tick(ship_tick), .shot_tick(shot_tick),
    .march_tick(march_tick), .return_tick(return_tick),
    .state(state), .score(score), .lives(lives)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int act);
    n_checks++;
    $display("FAIL %s: got %0d, expected nothing", name, act);
  endtask

  // monitor / scoreboard
  logic [2:0] m_st = 3'd0;
  logic [1:0] m_lives = 2'd3;
  logic [9:0] m_score = 10'd0;
  int cyc = 0;
  int last_ship = -1, last_shot = -1, last_ret = -1, last_march = -1;

  always @(negedge Clk) begin
    if (mon_en) begin
      cyc++;
      if ({state, lives} != {m_st, m_lives}) begin
        if (exp_st_q.size() == 0) fail_now("unexpected_state_change", int'(state));
        else begin
          logic [4:0] e;
          e = exp_st_q.pop_front();
          check("state", int'(state), int'(e[4:2]));
          check("lives", int'(lives), int'(e[1:0]));
        end
        m_st = state;
        m_lives = lives;
      end
      if (score != m_score) begin
        if (exp_score_q.size() == 0) fail_now("unexpected_score_change", int'(score));
        else check("score", int'(score), int'(exp_score_q.pop_front()));
        m_score = score;
      end
      if (dp_load) begin
        if (exp_load_q.size() == 0) fail_now("unexpected_dp_load", int'(state));
        else check("dp_load_state", int'(state), int'(exp_load_q.pop_front()));
      end
      if (ship_tick || shot_tick || march_tick || return_tick)
        check("tick_only_in_play", int'(state), int'(ST_PLAY));
      if (state != 3'(ST_PLAY)) begin
        last_ship = -1; last_shot = -1; last_ret = -1; last_march = -1;
      end else begin
        if (ship_tick) begin
          if (last_ship >= 0) check("ship_gap", cyc - last_ship, FDIV);
          last_ship = cyc;
        end
        if (shot_tick) begin
          if (last_shot >= 0) check("shot_gap", cyc - last_shot, FDIV);
          last_shot = cyc;
        end
        if (return_tick) begin
          if (last_ret >= 0) check("return_gap", cyc - last_ret, 2 * FDIV);
          last_ret = cyc;
        end
        if (march_tick) begin
          if (last_march >= 0 && exp_march_gap > 0)
            check("march_gap", cyc - last_march, exp_march_gap);
          last_march = cyc;
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_hit(input bit a, input bit p);
    step();
    alien_hit = a;
    player_hit = p;
    step();
    alien_hit = 1'b0;
    player_hit = 1'b0;
  endtask

  task automatic push_st(input game_state_t s, input int l);
    exp_st_q.push_back({3'(s), 2'(l)});
  endtask

  task automatic push_round(input int l);
    push_st(ST_LOAD, l);
    push_st(ST_PLAY, l);
    exp_load_q.push_back(3'(ST_LOAD));
  endtask

  task automatic wait_state(input game_state_t s, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge Clk);
      if (state == 3'(s)) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL timeout_%s: state %0d, expected %0d", name, state, s);
    end
  endtask

  task automatic wait_march(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge Clk);
      if (march_tick) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL timeout_%s: march_tick %0d, expected 1", name, march_tick);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    #2 reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_score", int'(score), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_outputs", int'({dp_load, ship_tick, shot_tick, march_tick, return_tick}), 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // new game, full fleet: march every 34 frames
    exp_march_gap = 34 * FDIV;
    push_round(3);
    start = 1'b1;
    wait_state(ST_PLAY, 20, "first_play");
    step();
    start = 1'b0;
    wait_march(200, "march_a");
    wait_march(200, "march_b");
    step();
    exp_march_gap = 6 * FDIV;
    aliens_left = 4'd1;
    wait_march(60, "march_c");
    wait_march(60, "march_d");

    // simultaneous alien_hit + player_hit, then hits inside HIT
    push_st(ST_HIT, 2);
    exp_score_q.push_back(10'd10);
    pulse_hit(1'b1, 1'b1);
    exp_score_q.push_back(10'd20);
    pulse_hit(1'b1, 1'b0);
    pulse_hit(1'b0, 1'b1);
    push_round(2);
    wait_state(ST_PLAY, 40, "round2");
    hits = 2;

    // score saturation at 999
    for (int i = 0; i < 100; i++) begin
      if (hits < 100) begin
        hits++;
        exp_score_q.push_back((hits * 10 > 999) ? 10'd999 : 10'(hits * 10));
      end
      pulse_hit(1'b1, 1'b0);
    end

    // remaining lives
    push_st(ST_HIT, 1);
    push_round(1);
    pulse_hit(1'b0, 1'b1);
    wait_state(ST_PLAY, 40, "round3");
    push_st(ST_LOSE, 0);
    pulse_hit(1'b0, 1'b1);
    wait_state(ST_LOSE, 5, "lose");
    repeat (5) step();

    // LOSE -> IDLE on start edge; alien_hit ignored in IDLE; fresh game
    push_st(ST_IDLE, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_state(ST_IDLE, 5, "idle_after_lose");
    pulse_hit(1'b1, 1'b0);
    repeat (2) step();
    push_round(3);
    exp_score_q.push_back(10'd0);
    start = 1'b1;
    wait_state(ST_PLAY, 10, "game2");
    step();
    start = 1'b0;

    // exit priority: no aliens beats invaded and player_hit
    exp_march_gap = 0;
    push_st(ST_WIN, 3);
    step();
    aliens_left = 4'd0;
    invaded = 1'b1;
    player_hit = 1'b1;
    step();
    invaded = 1'b0;
    player_hit = 1'b0;
    wait_state(ST_WIN, 3, "win");
    repeat (4) step();

    // async reset in the middle of HIT
    aliens_left = 4'd5;
    push_st(ST_IDLE, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_state(ST_IDLE, 5, "idle_after_win");
    exp_march_gap = 14 * FDIV;
    push_round(3);
    start = 1'b1;
    wait_state(ST_PLAY, 10, "game3");
    step();
    start = 1'b0;
    push_st(ST_HIT, 2);
    exp_score_q.push_back(10'd10);
    pulse_hit(1'b1, 1'b1);
    wait_state(ST_HIT, 5, "hit_before_reset");
    repeat (2) step();
    push_st(ST_IDLE, 3);
    exp_score_q.push_back(10'd0);
    @(negedge Clk);
    #1 reset = 1'b1;
    #2;
    check("async_rst_state", int'(state), 0);
    check("async_rst_score", int'(score), 0);
    check("async_rst_lives", int'(lives), 3);
    check("async_rst_dp_load", int'(dp_load), 0);
    repeat (2) @(posedge Clk);
    #1 reset = 1'b0;
    push_round(3);
    start = 1'b1;
    wait_state(ST_PLAY, 10, "game4");
    step();
    start = 1'b0;
    repeat (20) step();

    // final report
    check("state_queue_left", exp_st_q.size(), 0);
    check("score_queue_left", exp_score_q.size(), 0);
    check("load_queue_left", exp_load_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
